// File: rtl/draw_mole.sv
// Mole sprite overlay: composites a 32x64 ROM sprite over the incoming VGA pixel stream.
// Latency: 2 clk from any input pixel to its outputs; all outputs stay mutually aligned.
// Backpressure: none; the video stream advances every clk and this block never stalls it.
//
// Ports:
//   clk, rst                 pixel clock and synchronous active-high reset
//   hcount_in .. vblnk_in    upstream timing (counters and strobes)
//   rgb_in                   upstream pixel colour {R4,G4,B4}
//   xpos, ypos               mole top-left position from game logic, sampled at vblank entry
//   rgb_pixel / pixel_addr   sprite ROM data / address ({row, col}), ROM is 1-clk synchronous
//   hcount_out .. vblnk_out  timing delayed by 2 clk
//   rgb_out                  composited colour delayed by 2 clk
module draw_mole #(
   parameter int          MOLE_WIDTH  = 32,
   parameter int          MOLE_HEIGHT = 64,
   parameter logic [11:0] TRANSPARENT = 12'h0F0,
   parameter int          OFF_X       = 900,
   parameter int          OFF_Y       = 800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic [11:0] rgb_pixel,
   output logic [10:0] pixel_addr,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int COL_W = $clog2(MOLE_WIDTH);
   localparam int ROW_W = $clog2(MOLE_HEIGHT);

   // ------------------------------------------------------------------
   // Position latch, updated only on vblank entry so a frame never tears
   // ------------------------------------------------------------------
   logic        vblnk_prev;
   logic        vblnk_rise;
   logic [11:0] x_lat;
   logic [11:0] y_lat;

   assign vblnk_rise = vblnk_in & ~vblnk_prev;

   // vblnk_prev resets to 1 so a reset released inside vblank waits for the
   // next vblank before picking up a position.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev <= 1'b1;
         x_lat      <= 12'(OFF_X);
         y_lat      <= 12'(OFF_Y);
      end else begin
         vblnk_prev <= vblnk_in;
         if (vblnk_rise) begin
            x_lat <= xpos;
            y_lat <= ypos;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: hit test and ROM address
   // ------------------------------------------------------------------
   // 13-bit arithmetic keeps x_lat+MOLE_WIDTH from wrapping, so a sprite
   // clipped at the right/bottom edge never reappears at the left/top.
   logic [12:0] h_ext, v_ext, x_ext, y_ext;
   logic [12:0] dx, dy;
   logic        hit;
   logic        unused_bits;

   always_comb begin
      h_ext      = {2'b00, hcount_in};
      v_ext      = {2'b00, vcount_in};
      x_ext      = {1'b0, x_lat};
      y_ext      = {1'b0, y_lat};
      dx         = h_ext - x_ext;
      dy         = v_ext - y_ext;
      hit        = (h_ext >= x_ext) && (h_ext < x_ext + 13'(MOLE_WIDTH)) &&
                   (v_ext >= y_ext) && (v_ext < y_ext + 13'(MOLE_HEIGHT));
      pixel_addr = '0;
      // The address is presented combinationally: the ROM's own read register
      // forms stage 1 of the data path, so rgb_pixel lines up with the stage-1
      // registers below and the overall latency stays at 2 clk.
      if (hit && !rst)
         pixel_addr = 11'({dy[ROW_W-1:0], dx[COL_W-1:0]});
   end

   assign unused_bits = ^{dx[12:COL_W], dy[12:ROW_W]};

   logic [10:0] s1_hcount, s1_vcount;
   logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
   logic [11:0] s1_rgb;
   logic        s1_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hcount <= '0;
         s1_vcount <= '0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_hblnk  <= 1'b0;
         s1_vblnk  <= 1'b0;
         s1_rgb    <= '0;
         s1_hit    <= 1'b0;
      end else begin
         s1_hcount <= hcount_in;
         s1_vcount <= vcount_in;
         s1_hsync  <= hsync_in;
         s1_vsync  <= vsync_in;
         s1_hblnk  <= hblnk_in;
         s1_vblnk  <= vblnk_in;
         s1_rgb    <= rgb_in;
         s1_hit    <= hit;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: compositing
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= s1_hcount;
         vcount_out <= s1_vcount;
         hsync_out  <= s1_hsync;
         vsync_out  <= s1_vsync;
         hblnk_out  <= s1_hblnk;
         vblnk_out  <= s1_vblnk;
         if (s1_hblnk || s1_vblnk)
            rgb_out <= 12'h000;
         else if (s1_hit && (rgb_pixel != TRANSPARENT))
            rgb_out <= rgb_pixel;
         else
            rgb_out <= s1_rgb;
      end
   end

endmodule
